// File: rtl/frequency_lock_monitor_if.sv
// frequency_lock_monitor_if: sample input and status output bundle of the lock monitor
// master: drives frequency_in/valid_in/clear_extremes, reads the status outputs
// slave: the monitor side
interface frequency_lock_monitor_if;
  logic [31:0] frequency_in;
  logic valid_in;
  logic clear_extremes;
  logic in_window;
  logic locked;
  logic lock_lost;
  logic [31:0] average;
  logic average_valid;
  logic [31:0] minimum;
  logic [31:0] maximum;
  logic [15:0] sample_count;
  modport master (
    output frequency_in, valid_in, clear_extremes,
    input in_window, locked, lock_lost, average, average_valid, minimum, maximum, sample_count
  );
  modport slave (
    input frequency_in, valid_in, clear_extremes,
    output in_window, locked, lock_lost, average, average_valid, minimum, maximum, sample_count
  );
endinterface

// File: rtl/frequency_lock_monitor.sv
// frequency_lock_monitor: window/hysteresis lock detection, boxcar average and min/max of frequency samples
// clock, reset (async, active-high); bus: frequency_in/valid_in/clear_extremes in,
// in_window/locked/lock_lost/average/average_valid/minimum/maximum/sample_count out (all registered)
module frequency_lock_monitor #(
  parameter logic [31:0] EXPECTED_FREQUENCY = 32'd100000000,
  parameter logic [31:0] TOLERANCE = 32'd1000,
  parameter int LOCK_COUNT = 4,
  parameter int UNLOCK_COUNT = 2,
  parameter int LOG2_OF_AVERAGE_DEPTH = 2
) (
  input logic clock,
  input logic reset,
  frequency_lock_monitor_if.slave bus
);
  localparam int DEPTH = 1 << LOG2_OF_AVERAGE_DEPTH;
  localparam int SW = 32 + LOG2_OF_AVERAGE_DEPTH;
  localparam logic [31:0] LOW = EXPECTED_FREQUENCY >= TOLERANCE ? EXPECTED_FREQUENCY - TOLERANCE : 32'd0;
  localparam logic [32:0] HIGH33 = {1'b0, EXPECTED_FREQUENCY} + {1'b0, TOLERANCE};
  localparam logic [31:0] HIGH = HIGH33[32] ? 32'hFFFF_FFFF : HIGH33[31:0];
  localparam logic [15:0] LC = 16'(LOCK_COUNT);
  localparam logic [15:0] UC = 16'(UNLOCK_COUNT);
  localparam logic [15:0] D_M1 = 16'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, ACQUIRING, LOCKED} state_t;
  state_t state, state_n;
  logic [15:0] good, good_n, bad, bad_n;
  logic lost_n, win, first, load;
  logic [31:0] hist [DEPTH];
  logic [SW-1:0] sum, sum_n;
  assign win = bus.frequency_in >= LOW && bus.frequency_in <= HIGH;
  assign load = first | bus.clear_extremes;
  // the oldest history slot is zero until filled, so the sum is zero-padded during warm-up
  assign sum_n = sum + SW'(bus.frequency_in) - SW'(hist[DEPTH-1]);
  always_comb begin
    state_n = state;
    good_n = good;
    bad_n = bad;
    lost_n = 1'b0;
    if (bus.valid_in)
      case (state)
        IDLE: if (win) begin
          good_n = 16'd1;
          state_n = LC == 16'd1 ? LOCKED : ACQUIRING;
        end
        ACQUIRING: begin
          good_n = win ? good + 16'd1 : 16'd0;
          state_n = !win ? IDLE : good_n == LC ? LOCKED : ACQUIRING;
        end
        LOCKED: begin
          bad_n = win ? 16'd0 : bad + 16'd1;
          if (bad_n == UC) begin
            state_n = IDLE;
            good_n = 16'd0;
            bad_n = 16'd0;
            lost_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      good <= '0;
      bad <= '0;
      sum <= '0;
      first <= 1'b1;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      bus.in_window <= 1'b0;
      bus.locked <= 1'b0;
      bus.lock_lost <= 1'b0;
      bus.average <= '0;
      bus.average_valid <= 1'b0;
      bus.minimum <= '0;
      bus.maximum <= '0;
      bus.sample_count <= '0;
    end else begin
      state <= state_n;
      good <= good_n;
      bad <= bad_n;
      bus.lock_lost <= lost_n;
      if (bus.valid_in) begin
        hist[0] <= bus.frequency_in;
        for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
        sum <= sum_n;
        first <= 1'b0;
        bus.in_window <= win;
        bus.locked <= state_n == LOCKED;
        bus.average <= sum_n[LOG2_OF_AVERAGE_DEPTH +: 32];
        bus.average_valid <= bus.average_valid | (bus.sample_count >= D_M1);
        bus.minimum <= load || bus.frequency_in < bus.minimum ? bus.frequency_in : bus.minimum;
        bus.maximum <= load || bus.frequency_in > bus.maximum ? bus.frequency_in : bus.maximum;
        bus.sample_count <= bus.sample_count + 16'(bus.sample_count != 16'hFFFF);
      end else if (bus.clear_extremes) first <= 1'b1;
    end
endmodule
